// File: rtl/ft245_device_emu_if.sv
// FT245 bus strobes/flags plus the USB-side valid/ready stream pair.
// The device end uses the slave modport; a controller model or bench uses master.
interface ft245_device_emu_if;
    logic       ReadStrobe;
    logic       WriteStrobe;
    logic       ReadOK;
    logic       WriteOK;
    logic [7:0] HostWrData;
    logic       HostWrValid;
    logic       HostWrReady;
    logic [7:0] HostRdData;
    logic       HostRdValid;
    logic       HostRdReady;

    modport slave (
        input  ReadStrobe,
        input  WriteStrobe,
        input  HostWrData,
        input  HostWrValid,
        input  HostRdReady,
        output ReadOK,
        output WriteOK,
        output HostWrReady,
        output HostRdData,
        output HostRdValid
    );

    modport master (
        output ReadStrobe,
        output WriteStrobe,
        output HostWrData,
        output HostWrValid,
        output HostRdReady,
        input  ReadOK,
        input  WriteOK,
        input  HostWrReady,
        input  HostRdData,
        input  HostRdValid
    );
endinterface

// File: rtl/ft245_device_emu.sv
// Device-side emulation of an FT245 USB FIFO: RX FIFO (host -> bus reads),
// TX FIFO (bus writes -> host), strobe edge detection and post-transfer recovery.
module ft245_device_emu #(
    parameter int DEPTH_LOG2 = 4,
    parameter int RECOVERY   = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    inout  wire  [7:0]          Data,
    ft245_device_emu_if.slave   bus,
    output logic [DEPTH_LOG2:0] RxCount,
    output logic [DEPTH_LOG2:0] TxCount,
    output logic                Underrun,
    output logic                Overrun
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int REC_W = (RECOVERY < 1) ? 1 : $clog2(RECOVERY + 1);
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [REC_W-1:0]    REC_LOAD   = REC_W'(RECOVERY);

    logic [7:0] rx_mem [DEPTH];
    logic [7:0] tx_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] rx_wr_ptr_reg, rx_wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rx_rd_ptr_reg, rx_rd_ptr_next;
    logic [DEPTH_LOG2:0]   rx_count_reg,  rx_count_next;
    logic [DEPTH_LOG2-1:0] tx_wr_ptr_reg, tx_wr_ptr_next;
    logic [DEPTH_LOG2-1:0] tx_rd_ptr_reg, tx_rd_ptr_next;
    logic [DEPTH_LOG2:0]   tx_count_reg,  tx_count_next;
    logic [REC_W-1:0]      rx_rec_reg,    rx_rec_next;
    logic [REC_W-1:0]      tx_rec_reg,    tx_rec_next;
    logic                  rs_reg, ws_reg;
    logic                  underrun_reg,  underrun_next;
    logic                  overrun_reg,   overrun_next;
    logic                  live_reg;

    logic       rd_fall, wr_fall;
    logic       rx_empty, rx_full, tx_empty, tx_full;
    logic       rx_push, rx_pop, tx_push, tx_pop;
    logic [7:0] rd_data;

    always_comb begin
        rx_empty = (rx_count_reg == '0);
        rx_full  = (rx_count_reg == FULL_COUNT);
        tx_empty = (tx_count_reg == '0);
        tx_full  = (tx_count_reg == FULL_COUNT);

        // Edges come from registered strobe copies so a held-low strobe acts once.
        rd_fall = rs_reg & ~bus.ReadStrobe;
        wr_fall = ws_reg & ~bus.WriteStrobe;

        rx_push = bus.HostWrValid & ~rx_full;
        rx_pop  = rd_fall & ~rx_empty;
        tx_push = wr_fall & ~tx_full;
        tx_pop  = bus.HostRdReady & ~tx_empty;
    end

    always_comb begin
        rx_wr_ptr_next = rx_wr_ptr_reg;
        rx_rd_ptr_next = rx_rd_ptr_reg;
        rx_count_next  = rx_count_reg;
        tx_wr_ptr_next = tx_wr_ptr_reg;
        tx_rd_ptr_next = tx_rd_ptr_reg;
        tx_count_next  = tx_count_reg;

        if (rx_push) rx_wr_ptr_next = rx_wr_ptr_reg + 1'b1;
        if (rx_pop)  rx_rd_ptr_next = rx_rd_ptr_reg + 1'b1;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_next = rx_count_reg + 1'b1;
            2'b01:   rx_count_next = rx_count_reg - 1'b1;
            default: rx_count_next = rx_count_reg;
        endcase

        if (tx_push) tx_wr_ptr_next = tx_wr_ptr_reg + 1'b1;
        if (tx_pop)  tx_rd_ptr_next = tx_rd_ptr_reg + 1'b1;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_next = tx_count_reg + 1'b1;
            2'b01:   tx_count_next = tx_count_reg - 1'b1;
            default: tx_count_next = tx_count_reg;
        endcase
    end

    always_comb begin
        rx_rec_next = rx_rec_reg;
        tx_rec_next = tx_rec_reg;
        if (rx_pop)                rx_rec_next = REC_LOAD;
        else if (rx_rec_reg != '0) rx_rec_next = rx_rec_reg - 1'b1;
        if (tx_push)               tx_rec_next = REC_LOAD;
        else if (tx_rec_reg != '0) tx_rec_next = tx_rec_reg - 1'b1;

        underrun_next = underrun_reg | (rd_fall & rx_empty);
        overrun_next  = overrun_reg  | (wr_fall & tx_full);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
            rx_rec_reg    <= '0;
            tx_rec_reg    <= '0;
            rs_reg        <= 1'b1;
            ws_reg        <= 1'b1;
            underrun_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
            live_reg      <= 1'b0;
        end else begin
            rx_wr_ptr_reg <= rx_wr_ptr_next;
            rx_rd_ptr_reg <= rx_rd_ptr_next;
            rx_count_reg  <= rx_count_next;
            tx_wr_ptr_reg <= tx_wr_ptr_next;
            tx_rd_ptr_reg <= tx_rd_ptr_next;
            tx_count_reg  <= tx_count_next;
            rx_rec_reg    <= rx_rec_next;
            tx_rec_reg    <= tx_rec_next;
            rs_reg        <= bus.ReadStrobe;
            ws_reg        <= bus.WriteStrobe;
            underrun_reg  <= underrun_next;
            overrun_reg   <= overrun_next;
            live_reg      <= 1'b1;
        end
    end

    // Storage has no reset; pointers define validity, so reset discards contents.
    always_ff @(posedge Clock) begin
        if (Reset && rx_push) rx_mem[rx_wr_ptr_reg] <= bus.HostWrData;
        if (Reset && tx_push) tx_mem[tx_wr_ptr_reg] <= Data;
    end

    always_comb begin
        rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg];
    end

    assign Data = (Reset && !bus.ReadStrobe) ? rd_data : 8'hzz;

    // live_reg keeps both flags low while reset is held and for the reset edge itself.
    assign bus.ReadOK      = live_reg & ~rx_empty & (rx_rec_reg == '0);
    assign bus.WriteOK     = live_reg & ~tx_full  & (tx_rec_reg == '0);
    assign bus.HostWrReady = ~rx_full;
    assign bus.HostRdData  = tx_mem[tx_rd_ptr_reg];
    assign bus.HostRdValid = ~tx_empty;

    assign RxCount  = rx_count_reg;
    assign TxCount  = tx_count_reg;
    assign Underrun = underrun_reg;
    assign Overrun  = overrun_reg;
endmodule

// File: tb/tb_ft245_device_emu.sv
// Directed bench for ft245_device_emu: bus reads/writes, recovery, overrun,
// underrun, simultaneous push/pop and mid-stream reset.
module tb_ft245_device_emu;
    logic       Clock;
    logic       Reset;
    wire  [7:0] Data;
    logic [7:0] drv_data;
    logic       drv_oe;
    logic [4:0] RxCount;
    logic [4:0] TxCount;
    logic       Underrun;
    logic       Overrun;

    int n_cmp;
    int n_err;

    ft245_device_emu_if bus_if ();

    assign Data = drv_oe ? drv_data : 8'hzz;

    ft245_device_emu #(.DEPTH_LOG2(4), .RECOVERY(2)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Data     (Data),
        .bus      (bus_if),
        .RxCount  (RxCount),
        .TxCount  (TxCount),
        .Underrun (Underrun),
        .Overrun  (Overrun)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("  ok %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One complete bus write of a byte followed by strobe release.
    task automatic bus_write(input logic [7:0] b);
        drv_data = b;
        drv_oe = 1'b1;
        bus_if.WriteStrobe = 1'b0;
        tick();
        bus_if.WriteStrobe = 1'b1;
        drv_oe = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b0;
        drv_data = 8'h00;
        drv_oe = 1'b0;
        bus_if.ReadStrobe  = 1'b1;
        bus_if.WriteStrobe = 1'b1;
        bus_if.HostWrData  = 8'h00;
        bus_if.HostWrValid = 1'b0;
        bus_if.HostRdReady = 1'b0;
        repeat (3) tick();

        // 1. reset state and release
        check("rst_writeok", bus_if.WriteOK, 0);
        check("rst_readok", bus_if.ReadOK, 0);
        check("rst_rxcount", RxCount, 0);
        check("rst_txcount", TxCount, 0);
        Reset = 1'b1;
        tick();
        check("rel_writeok", bus_if.WriteOK, 1);
        check("rel_readok", bus_if.ReadOK, 0);
        check("rel_hostwrready", bus_if.HostWrReady, 1);
        check("rel_hostrdvalid", bus_if.HostRdValid, 0);

        // 2. host push then bus reads with recovery gap
        bus_if.HostWrValid = 1'b1;
        bus_if.HostWrData = 8'hA5;
        tick();
        bus_if.HostWrData = 8'h5A;
        tick();
        bus_if.HostWrValid = 1'b0;
        check("rx_cnt2", RxCount, 2);
        check("rx_readok", bus_if.ReadOK, 1);
        bus_if.ReadStrobe = 1'b0;
        #1;
        check("rd_data_a5", Data, 8'hA5);
        tick();
        check("rx_cnt_after_pop", RxCount, 1);
        check("rec_readok_c1", bus_if.ReadOK, 0);
        check("rd_head_5a", Data, 8'h5A);
        bus_if.ReadStrobe = 1'b1;
        tick();
        check("rec_readok_c2", bus_if.ReadOK, 0);
        tick();
        check("rec_readok_done", bus_if.ReadOK, 1);
        bus_if.ReadStrobe = 1'b0;
        #1;
        check("rd_data_5a", Data, 8'h5A);
        tick();
        bus_if.ReadStrobe = 1'b1;
        check("rx_cnt0", RxCount, 0);
        check("rx_readok_empty", bus_if.ReadOK, 0);

        // 3. bus write drained by host
        drv_data = 8'h3C;
        drv_oe = 1'b1;
        bus_if.WriteStrobe = 1'b0;
        tick();
        bus_if.WriteStrobe = 1'b1;
        drv_oe = 1'b0;
        check("tx_cnt1", TxCount, 1);
        check("tx_rdvalid", bus_if.HostRdValid, 1);
        check("tx_rddata", bus_if.HostRdData, 8'h3C);
        check("tx_rec_writeok", bus_if.WriteOK, 0);
        bus_if.HostRdReady = 1'b1;
        tick();
        bus_if.HostRdReady = 1'b0;
        check("tx_cnt_drained", TxCount, 0);
        check("tx_rdvalid_0", bus_if.HostRdValid, 0);
        tick();
        check("tx_writeok_back", bus_if.WriteOK, 1);

        // 4. fill TX, overrun on the 17th write, drain in order
        for (int i = 0; i < 16; i++) bus_write(8'h10 + 8'(i));
        repeat (2) tick();
        check("tx_full_cnt", TxCount, 16);
        check("tx_full_writeok", bus_if.WriteOK, 0);
        check("tx_no_overrun", Overrun, 0);
        bus_write(8'hEE);
        check("tx_overrun", Overrun, 1);
        check("tx_cnt_after_ovr", TxCount, 16);
        bus_if.HostRdReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tx_drain_%0d", i), bus_if.HostRdData, 32'(8'h10 + 8'(i)));
            tick();
        end
        bus_if.HostRdReady = 1'b0;
        check("tx_drain_cnt", TxCount, 0);

        // 5. underrun, then held-low strobe does not pop a newly arrived byte
        check("no_underrun", Underrun, 0);
        bus_if.ReadStrobe = 1'b0;
        #1;
        check("ur_data", Data, 8'h00);
        tick();
        check("underrun", Underrun, 1);
        check("ur_rxcnt", RxCount, 0);
        bus_if.HostWrValid = 1'b1;
        bus_if.HostWrData = 8'h77;
        tick();
        bus_if.HostWrValid = 1'b0;
        repeat (2) tick();
        check("held_low_cnt", RxCount, 1);
        check("held_low_data", Data, 8'h77);
        bus_if.ReadStrobe = 1'b1;
        tick();
        check("held_release_cnt", RxCount, 1);
        bus_if.ReadStrobe = 1'b0;
        tick();
        bus_if.ReadStrobe = 1'b1;
        check("held_pop_cnt", RxCount, 0);

        // 6. RX at 15: simultaneous host push and bus pop, order kept
        bus_if.HostWrValid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bus_if.HostWrData = 8'h40 + 8'(i);
            tick();
        end
        bus_if.HostWrValid = 1'b0;
        repeat (2) tick();
        check("rx_cnt15", RxCount, 15);
        bus_if.HostWrData = 8'h4F;
        bus_if.HostWrValid = 1'b1;
        bus_if.ReadStrobe = 1'b0;
        #1;
        check("sim_data_40", Data, 8'h40);
        tick();
        bus_if.HostWrValid = 1'b0;
        bus_if.ReadStrobe = 1'b1;
        check("sim_cnt15", RxCount, 15);
        tick();
        tick();
        for (int i = 0; i < 15; i++) begin
            bus_if.ReadStrobe = 1'b0;
            #1;
            check($sformatf("rx_order_%0d", i), Data, 32'(8'h41 + 8'(i)));
            tick();
            bus_if.ReadStrobe = 1'b1;
            repeat (2) tick();
        end
        check("rx_order_cnt", RxCount, 0);

        // mid-stream reset with data in both FIFOs and sticky flags set
        bus_if.HostWrValid = 1'b1;
        bus_if.HostWrData = 8'h55;
        tick();
        bus_if.HostWrValid = 1'b0;
        bus_write(8'h66);
        Reset = 1'b0;
        tick();
        check("mid_rst_rxcnt", RxCount, 0);
        check("mid_rst_txcnt", TxCount, 0);
        check("mid_rst_underrun", Underrun, 0);
        check("mid_rst_overrun", Overrun, 0);
        check("mid_rst_writeok", bus_if.WriteOK, 0);
        check("mid_rst_readok", bus_if.ReadOK, 0);
        Reset = 1'b1;
        tick();
        check("post_rst_writeok", bus_if.WriteOK, 1);
        bus_if.HostWrValid = 1'b1;
        bus_if.HostWrData = 8'h99;
        tick();
        bus_if.HostWrValid = 1'b0;
        bus_if.ReadStrobe = 1'b0;
        #1;
        check("post_rst_data", Data, 8'h99);
        tick();
        bus_if.ReadStrobe = 1'b1;
        check("post_rst_cnt", RxCount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
